// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light controller.
// The WALK state exists only when TLC_WALK_EN is defined.
package tlc_pkg;

  typedef enum logic [2:0] {
    ALL_RED_A   = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_B   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5
`ifdef TLC_WALK_EN
    , WALK      = 3'd6
`endif
  } state_t;

  localparam int unsigned LB_RM = 6;
  localparam int unsigned LB_YM = 5;
  localparam int unsigned LB_GM = 4;
  localparam int unsigned LB_RS = 3;
  localparam int unsigned LB_YS = 2;
  localparam int unsigned LB_GS = 1;
  localparam int unsigned LB_W  = 0;

  localparam logic [6:0] LT_ALL_RED_A   = 7'b1001000;
  localparam logic [6:0] LT_ALL_RED_B   = 7'b1001000;
  localparam logic [6:0] LT_MAIN_GREEN  = 7'b0011000;
  localparam logic [6:0] LT_MAIN_YELLOW = 7'b0101000;
  localparam logic [6:0] LT_SIDE_GREEN  = 7'b1000010;
  localparam logic [6:0] LT_SIDE_YELLOW = 7'b1000100;
  localparam logic [6:0] LT_WALK        = 7'b1001001;

  function automatic logic [6:0] lights_of(input state_t s);
    logic [6:0] l;
    l = LT_ALL_RED_A;
    case (s)
      ALL_RED_A:   l = LT_ALL_RED_A;
      MAIN_GREEN:  l = LT_MAIN_GREEN;
      MAIN_YELLOW: l = LT_MAIN_YELLOW;
      ALL_RED_B:   l = LT_ALL_RED_B;
      SIDE_GREEN:  l = LT_SIDE_GREEN;
      SIDE_YELLOW: l = LT_SIDE_YELLOW;
`ifdef TLC_WALK_EN
      WALK:        l = LT_WALK;
`endif
      default:     l = LT_ALL_RED_A;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-gated phase counter: clears on clr, saturates at limit-1, and flags
// expiry on a tick at the last count. A limit of 0 behaves as 1.
module phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] count;
  logic [7:0] last;

  assign last = (limit == 8'd0) ? 8'd0 : limit - 8'd1;
  assign done = tick && (count == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (tick && (count < last)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// Two-road traffic light controller with optional pedestrian phase.
// Define TLC_WALK_EN to build the WALK state and pedestrian request latch.
module traffic_fsm
  import tlc_pkg::*;
#(
  parameter logic [7:0] T_MG   = 8'd8,
  parameter logic [7:0] T_Y    = 8'd3,
  parameter logic [7:0] T_AR   = 8'd1,
  parameter logic [7:0] T_SG   = 8'd5,
  parameter logic [7:0] T_WALK = 8'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       side_req,
  input  logic       walk_req,
  output logic [6:0] lights
);

  state_t     state;
  state_t     state_next;
  logic [6:0] lights_next;
  logic [7:0] limit;
  logic       done;
  logic       walk_pend;
  logic [1:0] rst_sync;
  logic       rst_core_n;

  // Assert immediately, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_core_n = rst_sync[1];

  phase_timer u_timer (
    .clk   (clk),
    .rst_n (rst_core_n),
    .clr   (state_next != state),
    .tick  (tick),
    .limit (limit),
    .done  (done)
  );

`ifdef TLC_WALK_EN
  // A new request wins over the clear so a press during WALK is kept.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n)                               walk_pend <= 1'b0;
    else if (walk_req)                             walk_pend <= 1'b1;
    else if (state_next == WALK && state != WALK)  walk_pend <= 1'b0;
  end
`else
  logic unused_walk_req;
  assign unused_walk_req = walk_req;
  assign walk_pend       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state  <= ALL_RED_A;
      lights <= LT_ALL_RED_A;
    end else begin
      state  <= state_next;
      lights <= lights_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ALL_RED_A:   if (done) state_next = MAIN_GREEN;
      MAIN_GREEN:  if (done && (side_req || walk_pend)) state_next = MAIN_YELLOW;
      MAIN_YELLOW: if (done) state_next = ALL_RED_B;
`ifdef TLC_WALK_EN
      ALL_RED_B:   if (done) state_next = walk_pend ? WALK : SIDE_GREEN;
      WALK:        if (done) state_next = ALL_RED_A;
`else
      ALL_RED_B:   if (done) state_next = SIDE_GREEN;
`endif
      SIDE_GREEN:  if (done) state_next = SIDE_YELLOW;
      SIDE_YELLOW: if (done) state_next = ALL_RED_A;
      default:     state_next = ALL_RED_A;
    endcase
  end

  // Lights are decoded from the next state so they flip on the transition edge.
  always_comb begin
    lights_next = lights_of(state_next);
    limit       = T_AR;
    unique case (state)
      MAIN_GREEN:               limit = T_MG;
      MAIN_YELLOW, SIDE_YELLOW: limit = T_Y;
      SIDE_GREEN:               limit = T_SG;
`ifdef TLC_WALK_EN
      WALK:                     limit = T_WALK;
`endif
      default:                  limit = T_AR;
    endcase
  end

endmodule
